parity_chk_accum: RTL and testbench
===================================

Name: parity_chk_accum

Overview:
Next-generation UART Rx parity checker, parametrised in frame data width.
- Accumulates parity serially as data bits are sampled, so no parallel data bus is needed.
- Supports even, odd, mark and space parity, latched per frame.
- Reports per-frame error, frame-length error, a sticky error flag and a saturating error counter.
- Sits between the Rx bit sampler and the Rx FSM/status register.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9)
CNT_WIDTH, 8, width of saturating error counter

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, synchronous, active-high
PAR_EN  in  1  parity enabled for frame; sampled at frame_start
PAR_TYP  in  2  00 even, 01 odd, 10 mark, 11 space; sampled at frame_start
frame_start  in  1  one-cycle pulse at start bit; clears accumulator
data_bit_vld  in  1  strobe: sampled_bit is a data bit
par_chk_en  in  1  strobe: sampled_bit is the parity bit
sampled_bit  in  1  bit value from sampler
err_clr  in  1  clears sticky flag and counter
chk_done  out  1  one-cycle pulse, check result valid
par_err  out  1  result of last check, held until next chk_done
len_err  out  1  one-cycle pulse, parity strobe before DATA_WIDTH data bits
par_err_sticky  out  1  set on any error, cleared by err_clr
err_cnt  out  CNT_WIDTH  saturating count of par_err events

Behaviour:
- Reset: synchronous, active-high. All outputs are 0, state is IDLE, accumulator is 0 and bit count is 0.
- States:
  - IDLE:
    - frame_start -> ACCUM.
    - Latch PAR_EN and PAR_TYP; clear acc and bit_cnt.
  - ACCUM:
    - data_bit_vld: acc <= acc ^ sampled_bit; bit_cnt++.
    - When bit_cnt reaches DATA_WIDTH: go to WAIT_PAR if latched PAR_EN=1, otherwise go to IDLE with no chk_done.
    - par_chk_en in ACCUM (early): chk_done=1, par_err=1, len_err=1; go to IDLE.
  - WAIT_PAR:
    - par_chk_en: expected = acc (even), ~acc (odd), 1 (mark), 0 (space).
    - par_err <= (sampled_bit != expected); chk_done pulses; go to IDLE.
    - data_bit_vld in WAIT_PAR is ignored.
- Strobes in IDLE (data_bit_vld or par_chk_en without a frame) are ignored; no outputs change.
- Latency: chk_done and par_err are registered and appear the cycle after par_chk_en.
- frame_start in any state restarts the frame: re-latch config, clear acc and bit_cnt, go to ACCUM. It overrides any same-cycle strobe. par_err holds its old value.
- data_bit_vld and par_chk_en asserted together: par_chk_en takes priority; data bit dropped.
- PAR_TYP/PAR_EN changes mid-frame have no effect until the next frame_start.
- Error event means par_err set at chk_done (includes len_err). On an error event: par_err_sticky <= 1; err_cnt++, saturating at 2^CNT_WIDTH-1.
- err_clr clears par_err_sticky and err_cnt.
- err_clr in the same cycle as an error event: set wins; sticky=1, err_cnt=1.
- RST mid-frame returns to IDLE; the partial frame is discarded.

Optional Feature:
Macro PAR_ERR_CNT_EN.
- Defined: err_cnt counter implemented as above.
- Undefined: counter logic is removed; err_cnt is tied to 0. Sticky flag still works.

Decomposition:
- Package parity_chk_pkg holds:
  - PAR_TYP encodings PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11.
  - State encodings IDLE/ACCUM/WAIT_PAR.
- One natural sub-module: sat_err_cnt, a saturating counter with clear (parameter CNT_WIDTH; inc, clr, set-wins priority). Instantiated only under PAR_ERR_CNT_EN.

Test Plan:
- Even, data 0xA5 LSB-first (four ones), parity bit 0 -> chk_done one cycle after strobe, par_err=0, err_cnt=0.
- Odd, data 0xA5, parity bit 0 -> par_err=1, par_err_sticky=1, err_cnt=1.
- Mark, data 0x00, parity 0 -> par_err=1. Space, data 0xFF, parity 0 -> par_err=0.
- par_chk_en after 5 data bits (DATA_WIDTH=8) -> len_err=1, par_err=1, chk_done=1, state IDLE.
- CNT_WIDTH=2, five erroneous frames -> err_cnt=3 (saturated). err_clr coincident with the 6th error -> err_cnt=1, sticky=1.
- frame_start after 4 data bits, then a full good even frame 0x0F with parity 0 -> par_err=0. RST asserted mid-frame -> all outputs 0, following strobes ignored until frame_start.

Source files
------------

// File: rtl/parity_chk_accum_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : parity_chk_pkg                                            |
// | Brief    : Parity type encodings, FSM states and expected-bit helper |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package parity_chk_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    WAIT_PAR = 2'd2
  } state_t;

  // acc holds the XOR of all data bits, i.e. the even-parity bit
  function automatic logic expected_par(input logic [1:0] typ, input logic acc);
    case (typ)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_err_cnt.sv
// +----------------------------------------------------------------------+
// | Module   : sat_err_cnt                                               |
// | Brief    : Saturating event counter with clear; increment beats clear|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_err_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_inc,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] c_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cnt;

  // A clear coinciding with an event counts that event from zero
  always_ff @(posedge CLK) begin
    if (RST)
      r_cnt <= '0;
    else if (i_inc && i_clr)
      r_cnt <= c_ONE;
    else if (i_inc && (r_cnt != c_MAX))
      r_cnt <= r_cnt + c_ONE;
    else if (i_clr)
      r_cnt <= '0;
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/parity_chk_accum.sv
// +----------------------------------------------------------------------+
// | Module   : parity_chk_accum                                          |
// | Brief    : Serial UART Rx parity accumulator/checker with error stats|
// |            Optional macro PAR_ERR_CNT_EN enables the error counter.  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module parity_chk_accum
  import parity_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_TYP,
  input  logic                 frame_start,
  input  logic                 data_bit_vld,
  input  logic                 par_chk_en,
  input  logic                 sampled_bit,
  input  logic                 err_clr,
  output logic                 chk_done,
  output logic                 par_err,
  output logic                 len_err,
  output logic                 par_err_sticky,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int                  c_BCNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [c_BCNT_W-1:0] c_LAST   = c_BCNT_W'(DATA_WIDTH - 1);
  localparam logic [c_BCNT_W-1:0] c_ONE    = c_BCNT_W'(1);

  state_t              r_state, w_state_nxt;
  logic                r_par_en, w_par_en_nxt;
  logic [1:0]          r_par_typ, w_par_typ_nxt;
  logic                r_acc, w_acc_nxt;
  logic [c_BCNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic                r_chk_done, w_chk_done_nxt;
  logic                r_par_err, w_par_err_nxt;
  logic                r_len_err, w_len_err_nxt;
  logic                r_sticky;
  logic                w_err_evt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_par_en   <= 1'b0;
      r_par_typ  <= PAR_EVEN;
      r_acc      <= 1'b0;
      r_bit_cnt  <= '0;
      r_chk_done <= 1'b0;
      r_par_err  <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_typ  <= w_par_typ_nxt;
      r_acc      <= w_acc_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_chk_done <= w_chk_done_nxt;
      r_par_err  <= w_par_err_nxt;
      r_len_err  <= w_len_err_nxt;
    end
  end

  // frame_start outranks every strobe; par_chk_en outranks data_bit_vld
  always_comb begin
    w_state_nxt    = r_state;
    w_par_en_nxt   = r_par_en;
    w_par_typ_nxt  = r_par_typ;
    w_acc_nxt      = r_acc;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_chk_done_nxt = 1'b0;
    w_par_err_nxt  = r_par_err;
    w_len_err_nxt  = 1'b0;
    if (frame_start) begin
      w_state_nxt   = ACCUM;
      w_par_en_nxt  = PAR_EN;
      w_par_typ_nxt = PAR_TYP;
      w_acc_nxt     = 1'b0;
      w_bit_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: ;
        ACCUM: begin
          if (par_chk_en) begin
            w_chk_done_nxt = 1'b1;
            w_par_err_nxt  = 1'b1;
            w_len_err_nxt  = 1'b1;
            w_state_nxt    = IDLE;
          end else if (data_bit_vld) begin
            w_acc_nxt     = r_acc ^ sampled_bit;
            w_bit_cnt_nxt = r_bit_cnt + c_ONE;
            if (r_bit_cnt == c_LAST)
              w_state_nxt = r_par_en ? WAIT_PAR : IDLE;
          end
        end
        WAIT_PAR: begin
          if (par_chk_en) begin
            w_chk_done_nxt = 1'b1;
            w_par_err_nxt  = (sampled_bit != expected_par(r_par_typ, r_acc));
            w_state_nxt    = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_err_evt = w_chk_done_nxt & w_par_err_nxt;

  always_ff @(posedge CLK) begin
    if (RST)
      r_sticky <= 1'b0;
    else if (w_err_evt)
      r_sticky <= 1'b1;
    else if (err_clr)
      r_sticky <= 1'b0;
  end

`ifdef PAR_ERR_CNT_EN
  sat_err_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat_err_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .i_inc (w_err_evt),
    .i_clr (err_clr),
    .o_cnt (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

  assign chk_done       = r_chk_done;
  assign par_err        = r_par_err;
  assign len_err        = r_len_err;
  assign par_err_sticky = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_parity_chk_accum.sv
// +----------------------------------------------------------------------+
// | Module   : tb_parity_chk_accum                                       |
// | Brief    : Self-checking bench: vector table, corner sequences and   |
// |            random traffic against a frame-level reference model      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_parity_chk_accum;

  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          PAR_EN = 1'b0;
  logic [1:0]    PAR_TYP = 2'b00;
  logic          frame_start = 1'b0;
  logic          data_bit_vld = 1'b0;
  logic          par_chk_en = 1'b0;
  logic          sampled_bit = 1'b0;
  logic          err_clr = 1'b0;
  logic          chk_done, par_err, len_err, par_err_sticky;
  logic [CW-1:0] err_cnt;

  int checks = 0;
  int failures = 0;

  parity_chk_accum #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .frame_start    (frame_start),
    .data_bit_vld   (data_bit_vld),
    .par_chk_en     (par_chk_en),
    .sampled_bit    (sampled_bit),
    .err_clr        (err_clr),
    .chk_done       (chk_done),
    .par_err        (par_err),
    .len_err        (len_err),
    .par_err_sticky (par_err_sticky),
    .err_cnt        (err_cnt)
  );

  always #5 CLK = ~CLK;

  // Frame-level reference: counts data bits and ones in the current frame
  bit       m_in_frame = 0;
  int       m_nbits = 0;
  int       m_ones = 0;
  bit       m_pen = 0;
  bit [1:0] m_typ = 0;
  int       m_cnt = 0;
  bit       e_done = 0, e_err = 0, e_len = 0, e_sticky = 0;
  int       e_cnt = 0;

  task automatic model(input bit rst, fs, pen, input bit [1:0] typ,
                       input bit dv, pc, sb, clr);
    bit want;
    e_done = 0;
    e_len  = 0;
    if (rst) begin
      m_in_frame = 0; m_nbits = 0; m_ones = 0; m_cnt = 0;
      e_err = 0; e_sticky = 0;
    end else begin
      if (fs) begin
        m_in_frame = 1; m_nbits = 0; m_ones = 0; m_pen = pen; m_typ = typ;
      end else if (m_in_frame) begin
        if (pc) begin
          e_done = 1;
          if (m_nbits < DW) begin
            e_err = 1; e_len = 1;
          end else begin
            case (m_typ)
              2'b00:   want = (m_ones % 2) == 1;
              2'b01:   want = (m_ones % 2) == 0;
              2'b10:   want = 1;
              default: want = 0;
            endcase
            e_err = (sb != want);
          end
          m_in_frame = 0;
        end else if (dv && m_nbits < DW) begin
          m_nbits++;
          m_ones += int'(sb);
          if (m_nbits == DW && !m_pen) m_in_frame = 0;
        end
      end
      if (e_done && e_err) begin
        e_sticky = 1;
        m_cnt = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
      end else if (clr) begin
        e_sticky = 0;
        m_cnt = 0;
      end
    end
`ifdef PAR_ERR_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 0;
`endif
  endtask

  task automatic step(input bit rst, fs, pen, input bit [1:0] typ,
                      input bit dv, pc, sb, clr, input string nm);
    RST = rst; frame_start = fs; PAR_EN = pen; PAR_TYP = typ;
    data_bit_vld = dv; par_chk_en = pc; sampled_bit = sb; err_clr = clr;
    model(rst, fs, pen, typ, dv, pc, sb, clr);
    @(posedge CLK);
    #1;
    checks++;
    if (chk_done !== e_done || par_err !== e_err || len_err !== e_len ||
        par_err_sticky !== e_sticky || int'(err_cnt) != e_cnt) begin
      failures++;
      $display("FAIL %s @%0t: got done=%0b err=%0b len=%0b sticky=%0b cnt=%0d, want done=%0b err=%0b len=%0b sticky=%0b cnt=%0d",
               nm, $time, chk_done, par_err, len_err, par_err_sticky, err_cnt,
               e_done, e_err, e_len, e_sticky, e_cnt);
    end
  endtask

  task automatic expect_val(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic idle(input string nm);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, nm);
  endtask

  task automatic frame(input bit [1:0] typ, input bit [7:0] data, input bit pbit);
    bit [7:0] d;
    d = data;
    step(0, 1, 1, typ, 0, 0, 0, 0, "frame_start");
    for (int i = 0; i < DW; i++) step(0, 0, 1, typ, 1, 0, d[i], 0, "data_bit");
    step(0, 0, 1, typ, 0, 1, pbit, 0, "parity_bit");
  endtask

  typedef struct {
    bit [1:0] typ;
    bit [7:0] data;
    bit       pbit;
    bit       exp_err;
  } vec_t;

  vec_t tv[7];

  initial begin
    int cnt_exp;
`ifdef PAR_ERR_CNT_EN
    cnt_exp = 1;
`else
    cnt_exp = 0;
`endif
    tv[0] = '{2'b00, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{2'b01, 8'hA5, 1'b0, 1'b1};
    tv[2] = '{2'b10, 8'h00, 1'b0, 1'b1};
    tv[3] = '{2'b11, 8'hFF, 1'b0, 1'b0};
    tv[4] = '{2'b00, 8'h0F, 1'b0, 1'b0};
    tv[5] = '{2'b01, 8'h01, 1'b1, 1'b1};
    tv[6] = '{2'b10, 8'hFF, 1'b1, 1'b0};

    // Reset state
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, "reset");
    step(1, 0, 0, 2'b00, 0, 0, 0, 0, "reset");
    idle("post_reset");

    // Strobes without a frame are ignored
    step(0, 0, 1, 2'b01, 1, 0, 1, 0, "idle_dv");
    step(0, 0, 1, 2'b01, 0, 1, 1, 0, "idle_pc");

    // Vector table
    for (int v = 0; v < 7; v++) begin
      frame(tv[v].typ, tv[v].data, tv[v].pbit);
      expect_val($sformatf("vec%0d_chk_done", v), int'(chk_done), 1);
      expect_val($sformatf("vec%0d_par_err", v), int'(par_err), int'(tv[v].exp_err));
      idle("after_vec");
    end

    // Early parity strobe after 5 data bits
    step(0, 0, 0, 2'b00, 0, 0, 0, 1, "clear");
    step(0, 1, 1, 2'b00, 0, 0, 0, 0, "early_start");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'b00, 1, 0, 1, 0, "early_data");
    step(0, 0, 1, 2'b00, 0, 1, 0, 0, "early_pc");
    expect_val("early_len_err", int'(len_err), 1);
    expect_val("early_par_err", int'(par_err), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'b00, 1, 0, 1, 0, "early_after_ignored");
    step(0, 0, 1, 2'b00, 0, 1, 1, 0, "early_pc_ignored");

    // Saturation of the error counter, then clear coincident with an error
    step(0, 0, 0, 2'b00, 0, 0, 0, 1, "clear");
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1, 2'b00, 0, 0, 0, 0, "sat_start");
      step(0, 0, 1, 2'b00, 1, 1, 1, 0, "sat_pc_with_dv");
    end
    idle("sat_idle");
    expect_val("sat_err_cnt", int'(err_cnt), cnt_exp * CMAX);
    step(0, 1, 1, 2'b00, 0, 0, 0, 0, "sat6_start");
    step(0, 0, 1, 2'b00, 0, 1, 0, 1, "sat6_pc_clr");
    expect_val("clr_vs_err_cnt", int'(err_cnt), cnt_exp);
    expect_val("clr_vs_err_sticky", int'(par_err_sticky), 1);
    step(0, 0, 0, 2'b00, 0, 0, 0, 1, "plain_clear");
    expect_val("plain_clear_sticky", int'(par_err_sticky), 0);

    // Restart mid-frame, then a good even frame
    step(0, 1, 1, 2'b01, 0, 0, 0, 0, "restart_start");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'b01, 1, 0, 1, 0, "restart_data");
    frame(2'b00, 8'h0F, 1'b0);
    expect_val("restart_par_err", int'(par_err), 0);
    expect_val("restart_chk_done", int'(chk_done), 1);

    // Reset mid-frame discards the frame
    frame(2'b01, 8'h00, 1'b0);
    step(0, 1, 1, 2'b00, 0, 0, 0, 0, "rst_mid_start");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b00, 1, 0, 1, 0, "rst_mid_data");
    step(1, 0, 1, 2'b00, 1, 0, 1, 0, "rst_mid");
    expect_val("rst_mid_sticky", int'(par_err_sticky), 0);
    expect_val("rst_mid_par_err", int'(par_err), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 2'b00, 1, 0, 1, 0, "rst_after_dv");
    step(0, 0, 1, 2'b00, 0, 1, 1, 0, "rst_after_pc");
    expect_val("rst_after_chk_done", int'(chk_done), 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit r_rst, r_fs, r_pen, r_dv, r_pc, r_sb, r_clr;
      bit [1:0] r_typ;
      r_rst = ($urandom % 300) == 0;
      r_fs  = ($urandom % 12) == 0;
      r_pen = ($urandom % 4) != 0;
      r_typ = 2'($urandom % 4);
      r_dv  = ($urandom % 3) != 0;
      r_pc  = ($urandom % 9) == 0;
      r_sb  = 1'($urandom % 2);
      r_clr = ($urandom % 40) == 0;
      step(r_rst, r_fs, r_pen, r_typ, r_dv, r_pc, r_sb, r_clr, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
